// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational gate, samples its output
// after a settle time and scores it against a truth table latched at start.
module truth_table_sequencer #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [2**N_IN-1:0]  i_tt,
    input  logic                i_dut_out,
    output logic [N_IN-1:0]     o_vec,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [N_IN:0]       o_err_cnt,
    output logic [N_IN-1:0]     o_fail_vec
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [NV-1:0]   tt_q;
    logic [NV-1:0]   tt_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] vec_d;
    logic [N_IN-1:0] fail_q;
    logic [N_IN-1:0] fail_d;
    logic [N_IN:0]   err_q;
    logic [N_IN:0]   err_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            pass_q;
    logic            pass_d;
    logic            mismatch;

    assign mismatch = (i_dut_out != tt_q[vec_q]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (vec_q == VEC_LAST) begin
                    next_state = DONE;
                end else begin
                    next_state = SETTLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        tt_d   = tt_q;
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        fail_d = fail_q;
        err_d  = err_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        unique case (state)
            IDLE: begin
                vec_d  = '0;
                busy_d = 1'b0;
                if (i_start) begin
                    tt_d   = i_tt;
                    cnt_d  = '0;
                    err_d  = '0;
                    fail_d = '0;
                    pass_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fail_d = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    // Verdict folds in the final vector so it is valid with o_done.
                    done_d = 1'b1;
                    pass_d = (err_q == '0) && !mismatch;
                end else begin
                    vec_d = vec_q + 1'b1;
                    cnt_d = '0;
                end
            end
            DONE: begin
                vec_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tt_q   <= '0;
            cnt_q  <= '0;
            vec_q  <= '0;
            fail_q <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            tt_q   <= tt_d;
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            fail_q <= fail_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign o_vec      = vec_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_pass     = pass_q;
    assign o_err_cnt  = err_q;
    assign o_fail_vec = fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer (N_IN=3, SETTLE_CYCLES=4)
// driving a behavioural gate selected by mode.
module tb_truth_table_sequencer;

    localparam int N_IN    = 3;
    localparam int SETTLE  = 4;
    localparam int LATENCY = (2**N_IN) * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tt = 8'h00;
    logic       dut_out;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;
    logic [1:0] mode = 2'd0;

    typedef struct {
        int err;
        int fail;
        int pass;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   done_total = 0;
    int   cycle = 0;

    truth_table_sequencer #(
        .N_IN(N_IN),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_tt(tt),
        .i_dut_out(dut_out),
        .o_vec(vec),
        .o_busy(busy),
        .o_done(done),
        .o_pass(pass),
        .o_err_cnt(err_cnt),
        .o_fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // gate under test: 0 and3, 1 or3, 2 stuck at 0
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            2'd0: dut_out = &vec;
            2'd1: dut_out = |vec;
            default: dut_out = 1'b0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor
    int   start_cyc = 0;
    int   dwell = 0;
    int   cur_vec = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                start_cyc = cycle;
                dwell = 1;
                cur_vec = int'(vec);
                check("first_vec", int'(vec), 0);
            end else if (busy) begin
                if (int'(vec) != cur_vec) begin
                    check("dwell", dwell, SETTLE + 1);
                    check("vec_step", int'(vec), cur_vec + 1);
                    cur_vec = int'(vec);
                    dwell = 1;
                end else begin
                    dwell++;
                end
            end
            if (done) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_cnt", int'(err_cnt), e.err);
                    check("pass", int'(pass), e.pass);
                    if (e.err != 0) begin
                        check("fail_vec", int'(fail_vec), e.fail);
                    end
                    check("latency", cycle - start_cyc, LATENCY);
                    check("done_vec", int'(vec), 7);
                    check("done_busy", int'(busy), 1);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [7:0] t,
                       input int e_err, input int e_fail, input int e_pass,
                       input string name);
        exp_t e;
        e.err = e_err;
        e.fail = e_fail;
        e.pass = e_pass;
        exp_q.push_back(e);
        mode = m;
        tt = t;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        repeat (3) @(negedge clk);
        check("rst_vec", int'(vec), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_fail", int'(fail_vec), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(2'd0, 8'h80, 0, 0, 1, "and3");
        run(2'd1, 8'h80, 6, 1, 0, "or3_vs_and");
        run(2'd2, 8'hFE, 7, 1, 0, "stuck0_fe");
        run(2'd2, 8'hFF, 8, 0, 0, "stuck0_ff");
        run(2'd2, 8'h80, 1, 7, 0, "last_vec_only");
        check("pass_held", int'(pass), 0);

        // start held high: two back-to-back runs, mid-run i_tt change ignored
        e.err = 0;
        e.fail = 0;
        e.pass = 1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        mode = 2'd0;
        tt = 8'h80;
        @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        tt = 8'h00;
        repeat (20) @(negedge clk);
        tt = 8'h80;
        wait_done("held_run1");
        wait_done("held_run2");
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("held_stop_busy", int'(busy), 0);
        check("held_runs_done", done_total, 7);

        // reset during vector 3 with mismatches already counted
        mode = 2'd2;
        tt = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vec != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec3", int'(vec), 3);
        check("pre_rst_err", int'(err_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vec", int'(vec), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err_cnt), 0);
        check("mid_rst_fail", int'(fail_vec), 0);
        check("mid_rst_pass", int'(pass), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_done_total", done_total, 7);

        run(2'd0, 8'h80, 0, 0, 1, "restart");
        check("final_pass", int'(pass), 1);
        check("queue_empty", exp_q.size(), 0);
        check("done_total", done_total, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
